buffer_ctrl: RTL and testbench

BUFFER_CTRL -- requirements
Module: buffer_ctrl

---
 rtl/buffer_ctrl_pkg.sv | 20 ++
 rtl/buffer_ctrl_if.sv | 32 +++
 rtl/buffer_ctrl_phase_timer.sv | 25 ++
 rtl/buffer_ctrl.sv | 157 +++++++++++++++
 tb/tb_buffer_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_ctrl_pkg.sv
// Shared QOI types: address/length widths and the buffer-ownership FSM state.
package qoi_types;
    localparam int ADDR_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [7:0]        byte_t;
    typedef logic [ADDR_W:0]   len_t;

    typedef enum logic [1:0] {
        CPU     = 2'd0,
        GUARD_E = 2'd1,
        ENC     = 2'd2,
        GUARD_C = 2'd3
    } buf_state_t;

    // Byte count implied by a write at address a, one bit wider so the top address cannot wrap.
    function automatic len_t addr_to_len(input addr_t a);
        return {1'b0, a} + len_t'(1);
    endfunction
endpackage

// File: rtl/buffer_ctrl_if.sv
// Bundle of CPU-side and encoder-side signals around the shared buffer controller.
interface buffer_ctrl_if;
    qoi_types::addr_t cpu_addr;
    logic             cpu_cs;
    logic             cpu_we;
    logic             cpu_go;
    logic             cpu_irq_ack;
    logic             cpu_ready;
    logic             irq;
    logic             err;
    logic             enc_cs;
    logic             enc_done;
    qoi_types::len_t  enc_out_len;
    logic             enc_start;
    qoi_types::len_t  enc_in_len;
    logic             sel;
    logic             cs_a;
    logic             cs_b;
    qoi_types::len_t  out_len;

    modport master (
        output cpu_addr, cpu_cs, cpu_we, cpu_go, cpu_irq_ack,
        output enc_cs, enc_done, enc_out_len,
        input  cpu_ready, irq, err, enc_start, enc_in_len, sel, cs_a, cs_b, out_len
    );

    modport slave (
        input  cpu_addr, cpu_cs, cpu_we, cpu_go, cpu_irq_ack,
        input  enc_cs, enc_done, enc_out_len,
        output cpu_ready, irq, err, enc_start, enc_in_len, sel, cs_a, cs_b, out_len
    );
endinterface

// File: rtl/buffer_ctrl_phase_timer.sv
// Watchdog for the encode phase: cleared on load, counts enabled cycles, flags the LIMIT-th one.
module phase_timer #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (count) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // LIMIT of 0 disables the watchdog entirely.
    assign expire = (LIMIT != 0) && count && (r_cnt == 16'(LIMIT - 1));
endmodule

// File: rtl/buffer_ctrl.sv
// Ping-pong ownership of a shared buffer between the CPU and the QOI encoder,
// with idle guard cycles around each handover and an encode-phase watchdog.
module buffer_ctrl
    import qoi_types::*;
#(
    parameter int GUARD_CYCLES = 1,
    parameter int TIMEOUT      = 65535,
    parameter int AUTO_GO      = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  addr_t cpu_addr,
    input  logic  cpu_cs,
    input  logic  cpu_we,
    input  logic  cpu_go,
    input  logic  cpu_irq_ack,
    output logic  cpu_ready,
    output logic  irq,
    output logic  err,
    input  logic  enc_cs,
    input  logic  enc_done,
    input  len_t  enc_out_len,
    output logic  enc_start,
    output len_t  enc_in_len,
    output logic  sel,
    output logic  cs_a,
    output logic  cs_b,
    output len_t  out_len
);
    logic [1:0]  r_rst_sync;
    logic        w_rst_n;
    buf_state_t  r_state;
    logic        r_sel;
    logic        r_cpu_ready;
    logic        r_a_en;
    logic        r_b_en;
    logic        r_enc_start;
    logic        r_irq;
    logic        r_err;
    len_t        r_in_len;
    len_t        r_out_len;
    logic [3:0]  r_guard;

    logic        w_wr;
    len_t        w_wr_len;
    len_t        w_eff_len;
    logic        w_go;
    logic        w_guard_last;
    logic        w_timer_load;
    logic        w_timer_count;
    logic        w_expire;

    // Assertion is immediate; release reaches the FSM two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_wr         = cpu_cs && cpu_we && (r_state == CPU);
    assign w_wr_len     = addr_to_len(cpu_addr);
    assign w_eff_len    = (w_wr && (w_wr_len > r_in_len)) ? w_wr_len : r_in_len;
    assign w_go         = cpu_go || ((AUTO_GO != 0) && cpu_cs && cpu_we && (cpu_addr == '1));
    assign w_guard_last = (r_guard == 4'(GUARD_CYCLES - 1));
    assign w_timer_load  = (r_state == GUARD_E) && w_guard_last;
    assign w_timer_count = (r_state == ENC);

    phase_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .load   (w_timer_load),
        .count  (w_timer_count),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= CPU;
            r_sel       <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_a_en      <= 1'b1;
            r_b_en      <= 1'b0;
            r_enc_start <= 1'b0;
            r_irq       <= 1'b0;
            r_err       <= 1'b0;
            r_in_len    <= '0;
            r_out_len   <= '0;
            r_guard     <= '0;
        end else begin
            r_enc_start <= 1'b0;
            if (cpu_irq_ack) r_irq <= 1'b0;
            case (r_state)
                CPU: begin
                    r_in_len <= w_eff_len;
                    if (w_go) begin
                        r_irq <= 1'b0;
                        r_err <= 1'b0;
                        if (w_eff_len != '0) begin
                            r_state     <= GUARD_E;
                            r_cpu_ready <= 1'b0;
                            r_a_en      <= 1'b0;
                            r_guard     <= '0;
                        end
                    end
                end
                GUARD_E: begin
                    if (w_guard_last) begin
                        r_state     <= ENC;
                        r_sel       <= 1'b1;
                        r_b_en      <= 1'b1;
                        r_enc_start <= 1'b1;
                        r_guard     <= '0;
                    end else begin
                        r_guard <= r_guard + 4'd1;
                    end
                end
                ENC: begin
                    // A completion on the watchdog's last cycle still counts as success.
                    if (enc_done) begin
                        r_out_len <= enc_out_len;
                        r_state   <= GUARD_C;
                        r_b_en    <= 1'b0;
                    end else if (w_expire) begin
                        r_err     <= 1'b1;
                        r_out_len <= '0;
                        r_state   <= GUARD_C;
                        r_b_en    <= 1'b0;
                    end
                end
                GUARD_C: begin
                    if (w_guard_last) begin
                        r_state     <= CPU;
                        r_sel       <= 1'b0;
                        r_a_en      <= 1'b1;
                        r_cpu_ready <= 1'b1;
                        r_irq       <= 1'b1;
                        r_in_len    <= '0;
                        r_guard     <= '0;
                    end else begin
                        r_guard <= r_guard + 4'd1;
                    end
                end
                default: r_state <= CPU;
            endcase
        end
    end

    assign sel        = r_sel;
    assign cpu_ready  = r_cpu_ready;
    assign cs_a       = r_a_en & cpu_cs;
    assign cs_b       = r_b_en & enc_cs;
    assign enc_start  = r_enc_start;
    assign enc_in_len = r_in_len;
    assign out_len    = r_out_len;
    assign irq        = r_irq;
    assign err        = r_err;
endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed scenarios for buffer_ctrl; a negedge monitor scores enc_start and irq events against queued expectations.
module tb_buffer_ctrl;
    import qoi_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    buffer_ctrl_if bus();

    buffer_ctrl #(.GUARD_CYCLES(1), .TIMEOUT(20), .AUTO_GO(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_addr    (bus.cpu_addr),
        .cpu_cs      (bus.cpu_cs),
        .cpu_we      (bus.cpu_we),
        .cpu_go      (bus.cpu_go),
        .cpu_irq_ack (bus.cpu_irq_ack),
        .cpu_ready   (bus.cpu_ready),
        .irq         (bus.irq),
        .err         (bus.err),
        .enc_cs      (bus.enc_cs),
        .enc_done    (bus.enc_done),
        .enc_out_len (bus.enc_out_len),
        .enc_start   (bus.enc_start),
        .enc_in_len  (bus.enc_in_len),
        .sel         (bus.sel),
        .cs_a        (bus.cs_a),
        .cs_b        (bus.cs_b),
        .out_len     (bus.out_len)
    );

    typedef struct {
        int out_len;
        int err;
    } done_t;

    int    n_chk = 0;
    int    n_err = 0;
    int    q_start[$];
    done_t q_done[$];
    logic  irq_q = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every start pulse and every irq rise must match a queued expectation.
    always @(negedge clk) begin
        if (bus.enc_start === 1'b1) begin
            if (q_start.size() == 0) begin
                chk("unexpected_enc_start", 1, 0);
            end else begin
                chk("enc_in_len_at_start", int'(bus.enc_in_len), q_start.pop_front());
                chk("sel_at_start", int'(bus.sel), 1);
            end
        end
        if (bus.irq === 1'b1 && irq_q === 1'b0) begin
            if (q_done.size() == 0) begin
                chk("unexpected_irq", 1, 0);
            end else begin
                done_t d;
                d = q_done.pop_front();
                chk("out_len_at_irq", int'(bus.out_len), d.out_len);
                chk("err_at_irq", int'(bus.err), d.err);
                chk("in_len_cleared_at_irq", int'(bus.enc_in_len), 0);
                chk("sel_at_irq", int'(bus.sel), 0);
            end
        end
        irq_q = bus.irq;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_addr = '0; bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_go = 0; bus.cpu_irq_ack = 0;
        bus.enc_cs = 0; bus.enc_done = 0; bus.enc_out_len = '0;

        // Reset state
        #2 rst_n = 1'b0;
        bus.cpu_cs = 1; bus.enc_cs = 1;
        #10;
        chk("rst_cs_a_follows", int'(bus.cs_a), 1);
        chk("rst_cs_b", int'(bus.cs_b), 0);
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_cpu_ready", int'(bus.cpu_ready), 1);
        chk("rst_enc_start", int'(bus.enc_start), 0);
        chk("rst_irq", int'(bus.irq), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_out_len", int'(bus.out_len), 0);
        chk("rst_in_len", int'(bus.enc_in_len), 0);
        bus.cpu_cs = 0; bus.enc_cs = 0;
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // Writes 0..9 then cpu_go: in_len 10, encoder returns 37
        for (int i = 0; i < 10; i++) begin
            bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_addr = addr_t'(i);
            step();
        end
        bus.cpu_cs = 0; bus.cpu_we = 0;
        bus.cpu_go = 1; q_start.push_back(10);
        step();
        bus.cpu_go = 0; bus.cpu_cs = 1;
        @(negedge clk);
        chk("guard_e_cs_a", int'(bus.cs_a), 0);
        chk("guard_e_cpu_ready", int'(bus.cpu_ready), 0);
        chk("guard_e_sel", int'(bus.sel), 0);
        step();
        bus.cpu_cs = 0; bus.enc_cs = 1;
        @(negedge clk);
        chk("enc_sel", int'(bus.sel), 1);
        chk("enc_cs_b", int'(bus.cs_b), 1);
        chk("enc_cs_a", int'(bus.cs_a), 0);
        step();
        bus.cpu_go = 1;
        step();
        bus.cpu_go = 0;
        step();
        @(negedge clk);
        chk("go_in_enc_ignored_sel", int'(bus.sel), 1);
        chk("enc_in_len_stable", int'(bus.enc_in_len), 10);
        bus.enc_done = 1; bus.enc_out_len = len_t'(37);
        q_done.push_back('{out_len: 37, err: 0});
        step();
        bus.enc_done = 0;
        @(negedge clk);
        chk("guard_c_sel_held", int'(bus.sel), 1);
        chk("guard_c_cs_b", int'(bus.cs_b), 0);
        step();
        @(negedge clk);
        chk("back_cpu_irq", int'(bus.irq), 1);
        chk("back_cpu_ready", int'(bus.cpu_ready), 1);
        chk("enc_cs_in_cpu_gated", int'(bus.cs_b), 0);
        bus.cpu_irq_ack = 1;
        step();
        bus.cpu_irq_ack = 0; bus.enc_cs = 0;
        @(negedge clk);
        chk("irq_acked", int'(bus.irq), 0);

        // Bare go with nothing written is ignored; then write+go in one cycle
        bus.cpu_go = 1;
        step();
        bus.cpu_go = 0;
        step();
        @(negedge clk);
        chk("empty_go_sel", int'(bus.sel), 0);
        chk("empty_go_ready", int'(bus.cpu_ready), 1);
        bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_addr = addr_t'(3);
        step();
        bus.cpu_addr = addr_t'(20); bus.cpu_go = 1; q_start.push_back(21);
        step();
        bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_go = 0;
        step();
        step();
        bus.enc_done = 1; bus.enc_out_len = len_t'(100);
        q_done.push_back('{out_len: 100, err: 0});
        step();
        bus.enc_done = 0; bus.cpu_irq_ack = 1;
        step();
        bus.cpu_irq_ack = 0;
        @(negedge clk);
        chk("irq_set_beats_ack", int'(bus.irq), 1);

        // Auto-go via all-ones write, no enc_done: watchdog fires on ENC cycle 20
        bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_addr = '1;
        q_start.push_back(256);
        q_done.push_back('{out_len: 0, err: 1});
        step();
        bus.cpu_cs = 0; bus.cpu_we = 0;
        @(negedge clk);
        chk("auto_go_clears_irq", int'(bus.irq), 0);
        repeat (20) step();
        @(negedge clk);
        chk("enc_cycle20_no_err_yet", int'(bus.err), 0);
        chk("enc_cycle20_sel", int'(bus.sel), 1);
        step();
        @(negedge clk);
        chk("timeout_err", int'(bus.err), 1);
        chk("timeout_out_len", int'(bus.out_len), 0);
        step();
        @(negedge clk);
        chk("timeout_back_cpu", int'(bus.cpu_ready), 1);
        bus.cpu_go = 1;
        step();
        bus.cpu_go = 0;
        @(negedge clk);
        chk("go_clears_err", int'(bus.err), 0);
        chk("go_clears_irq", int'(bus.irq), 0);

        // enc_done on the watchdog's final cycle wins
        bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_addr = '0; bus.cpu_go = 1;
        q_start.push_back(1);
        q_done.push_back('{out_len: 9, err: 0});
        step();
        bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_go = 0;
        repeat (20) step();
        bus.enc_done = 1; bus.enc_out_len = len_t'(9);
        step();
        bus.enc_done = 0;
        @(negedge clk);
        chk("tie_no_err", int'(bus.err), 0);
        step();
        step();

        // Reset mid-ENC: immediate release of the encoder, no irq afterwards
        bus.cpu_cs = 1; bus.cpu_we = 1; bus.cpu_addr = addr_t'(4); bus.cpu_go = 1;
        q_start.push_back(5);
        step();
        bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_go = 0;
        step();
        bus.enc_cs = 1;
        step();
        @(negedge clk);
        chk("pre_rst_cs_b", int'(bus.cs_b), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", int'(bus.sel), 0);
        chk("async_rst_cs_b", int'(bus.cs_b), 0);
        chk("async_rst_enc_start", int'(bus.enc_start), 0);
        chk("async_rst_cpu_ready", int'(bus.cpu_ready), 1);
        step();
        rst_n = 1'b1;
        bus.enc_cs = 0;
        repeat (4) step();
        @(negedge clk);
        chk("post_rst_irq", int'(bus.irq), 0);
        chk("post_rst_sel", int'(bus.sel), 0);
        chk("post_rst_in_len", int'(bus.enc_in_len), 0);

        chk("start_queue_drained", q_start.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
